// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : IF-stage fetch PC register and I-cache fetch sequencer. Holds
//            the fetch PC, issues I-cache reads, and presents the fetched
//            instruction to the branch controller and IF/ID barrier. Absorbs
//            redirects that arrive while a miss is outstanding by discarding
//            the stale response and restarting at the redirect target.
// Ports    : clk, reset_n (sync, active-low)
//            stall, pc_next, redirect_valid, redirect_pc  - pipeline control
//            icache_read, icache_address, icache_rdata, icache_resp - I-cache
//            stage_IF_pc, stage_IF_ir, stage_IF_valid      - IF stage output
//            debug_fetch_count, debug_discard_count        - debug counters
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [15:0] RESET_PC      = 16'h0000,
  parameter int          COUNTER_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     stall,
  input  logic [15:0]              pc_next,
  input  logic                     redirect_valid,
  input  logic [15:0]              redirect_pc,
  output logic                     icache_read,
  output logic [15:0]              icache_address,
  input  logic [15:0]              icache_rdata,
  input  logic                     icache_resp,
  output logic [15:0]              stage_IF_pc,
  output logic [15:0]              stage_IF_ir,
  output logic                     stage_IF_valid,
  output logic [COUNTER_WIDTH-1:0] debug_fetch_count,
  output logic [COUNTER_WIDTH-1:0] debug_discard_count
);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t                   state,         state_d;
  logic [15:0]              pc,            pc_d;
  logic                     pending,       pending_d;
  logic [15:0]              pending_pc,    pending_pc_d;
  logic [15:0]              ir_reg,        ir_reg_d;
  logic [COUNTER_WIDTH-1:0] fetch_count,   fetch_count_d;
  logic [COUNTER_WIDTH-1:0] discard_count, discard_count_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_FETCH;
      pc            <= RESET_PC;
      pending       <= 1'b0;
      pending_pc    <= 16'h0000;
      ir_reg        <= 16'h0000;
      fetch_count   <= '0;
      discard_count <= '0;
    end else begin
      state         <= state_d;
      pc            <= pc_d;
      pending       <= pending_d;
      pending_pc    <= pending_pc_d;
      ir_reg        <= ir_reg_d;
      fetch_count   <= fetch_count_d;
      discard_count <= discard_count_d;
    end
  end

  always_comb begin
    state_d         = state;
    pc_d            = pc;
    pending_d       = pending;
    pending_pc_d    = pending_pc;
    ir_reg_d        = ir_reg;
    fetch_count_d   = fetch_count;
    discard_count_d = discard_count;
    icache_read     = 1'b0;
    stage_IF_ir     = ir_reg;
    stage_IF_valid  = 1'b0;

    case (state)
      S_FETCH: begin
        icache_read    = 1'b1;
        stage_IF_ir    = icache_rdata;
        // A response is live only if no redirect (current or remembered)
        // has made it stale.
        stage_IF_valid = icache_resp & ~pending & ~redirect_valid;
        if (!icache_resp) begin
          // Miss outstanding: remember the newest redirect but keep the
          // address stable until the read completes.
          if (redirect_valid) begin
            pending_d    = 1'b1;
            pending_pc_d = redirect_pc;
          end
        end else if (pending || redirect_valid) begin
          discard_count_d = discard_count + COUNTER_WIDTH'(1);
          pc_d            = redirect_valid ? redirect_pc : pending_pc;
          pending_d       = 1'b0;
        end else if (!stall) begin
          pc_d          = pc_next;
          fetch_count_d = fetch_count + COUNTER_WIDTH'(1);
        end else begin
          ir_reg_d = icache_rdata;
          state_d  = S_HOLD;
        end
      end

      S_HOLD: begin
        stage_IF_valid = 1'b1;
        if (redirect_valid) begin
          pc_d            = redirect_pc;
          discard_count_d = discard_count + COUNTER_WIDTH'(1);
          state_d         = S_FETCH;
        end else if (!stall) begin
          pc_d          = pc_next;
          fetch_count_d = fetch_count + COUNTER_WIDTH'(1);
          state_d       = S_FETCH;
        end
      end

      default: state_d = S_FETCH;
    endcase
  end

  assign icache_address      = pc;
  assign stage_IF_pc         = pc;
  assign debug_fetch_count   = fetch_count;
  assign debug_discard_count = discard_count;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF-stage PC register and instruction-cache fetch sequencer, directly upstream of branch_controller.
- Holds the architectural fetch PC, issues reads to the I-cache, and presents stage_IF_ir, stage_IF_pc and stage_IF_valid to the branch controller and the IF/ID barrier.
- Loads the branch controller's pc_out as the next PC.
- Absorbs redirects that arrive while a miss is outstanding: the stale response is discarded and the fetch restarts at the redirect target.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
COUNTER_WIDTH, 16, width of the debug fetch/discard counters.

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  synchronous active-low reset
stall  input  1  pipeline stall; IF/ID cannot accept an instruction this cycle
pc_next  input  16  next PC (branch controller pc_out)
redirect_valid  input  1  flush/redirect request (IF/ID reset from branch controller)
redirect_pc  input  16  redirect target, valid with redirect_valid
icache_read  output  1  read request
icache_address  output  16  read address; equals stage_IF_pc
icache_rdata  input  16  instruction word, valid with icache_resp
icache_resp  input  1  read complete
stage_IF_pc  output  16  PC of the presented instruction
stage_IF_ir  output  16  presented instruction
stage_IF_valid  output  1  stage_IF_ir is a live instruction
debug_fetch_count  output  COUNTER_WIDTH  instructions handed to IF/ID
debug_discard_count  output  COUNTER_WIDTH  responses or held instructions dropped by redirects

Behaviour:
- Reset (reset_n=0 at an edge):
  - pc=RESET_PC; state=S_FETCH; pending=0; pending_pc=0; ir_reg=0; both counters=0.
  - Outputs after reset: icache_read=1, icache_address=RESET_PC, stage_IF_valid=0.
  - Reset overrides all other inputs, including mid-miss. A response arriving in the reset cycle is ignored.
- State S_FETCH:
  - icache_read=1; icache_address=pc.
  - stage_IF_valid = icache_resp & ~pending & ~redirect_valid.
  - stage_IF_ir = icache_rdata.
  - No resp, redirect_valid=1: pending<=1, pending_pc<=redirect_pc. The newest redirect overwrites any earlier one. pc is held so the address stays stable for the outstanding read.
  - Resp with pending=1 or redirect_valid=1: response dropped; discard_count++. pc<=redirect_pc if redirect_valid, else pending_pc. pending<=0. Stay in S_FETCH.
  - Resp, valid, stall=0: pc<=pc_next; fetch_count++; stay in S_FETCH. Back-to-back hits sustain 1 instruction/cycle.
  - Resp, valid, stall=1: ir_reg<=icache_rdata; go to S_HOLD.
- State S_HOLD:
  - icache_read=0; stage_IF_valid=1; stage_IF_ir=ir_reg; pc held.
  - redirect_valid=1: pc<=redirect_pc; discard_count++; go to S_FETCH. Redirect takes priority over stall.
  - Otherwise stall=0: pc<=pc_next; fetch_count++; go to S_FETCH.
  - Otherwise stay in S_HOLD.
- pc_next is sampled only when an instruction is accepted (valid & ~stall). It is ignored at all other times.
- redirect_valid always beats pc_next.
- PC arithmetic is 16-bit and wraps (0xFFFE -> 0x0000 via pc_next). pc[0] is passed through unchanged; the block does not check alignment.
- Counters wrap at 2^COUNTER_WIDTH.
- stage_IF_pc is always equal to pc.

Test Plan:
- Reset then hits: reset_n low 1 cycle, icache_resp=1 every cycle returning 0x1111, 0x2222, 0x3333, pc_next=pc+2 -> stage_IF_pc 0x0000, 0x0002, 0x0004 on consecutive cycles, valid every cycle, fetch_count=3.
- Miss with redirect: resp delayed 4 cycles at pc=0x0010, redirect_valid=1 with redirect_pc=0x0040 in cycle 2 -> icache_address stays 0x0010 until resp; response dropped (valid=0); next cycle address=0x0040; discard_count=1.
- Double redirect during a miss: redirects to 0x0040 then 0x0080 before resp -> fetch resumes at 0x0080; discard_count=1.
- Stall hold: hit returns 0xABCD with stall=1 for 3 cycles -> icache_read=0, ir=0xABCD, valid=1 held 3 cycles; stall drop loads pc_next=0x0022.
- Redirect in S_HOLD plus simultaneous resp/redirect: redirect_pc=0x0100 while held -> held instruction dropped, next address 0x0100. Resp and redirect_valid in the same S_FETCH cycle -> valid=0, pc=redirect_pc.
- Reset mid-miss with a pending redirect: reset_n low -> pending cleared, address=RESET_PC, counters=0, and the late response is not presented.
